// File: rtl/ose_pkg.sv
// Shared quadrature definitions for the encoder emulator and the decoder:
// Gray-coded (a,b) states, direction encoding and the detent sequence lookup.
package ose_pkg;

    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;
    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Position idx within a detent (0 = rest) mapped to {a,b}; up lets A lead, down lets B lead.
    function automatic logic [1:0] quad_state(input logic dir, input logic [1:0] idx);
        logic [1:0] qs;
        case (idx)
            2'd0:    qs = QS_11;
            2'd1:    qs = (dir == DIR_UP) ? QS_01 : QS_10;
            2'd2:    qs = QS_00;
            default: qs = (dir == DIR_UP) ? QS_10 : QS_01;
        endcase
        return qs;
    endfunction

endpackage

// File: rtl/encoder_phase_timer.sv
// Free-running modulo-phase_div counter that paces A/B transitions with a one-cycle tick.
module encoder_phase_timer #(
    parameter int unsigned phase_div = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic tick
);
    localparam int unsigned W = (phase_div > 1) ? $clog2(phase_div) : 1;
    localparam logic [W-1:0] LAST = W'(phase_div - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/ose_encoder_gen.sv
// Quadrature encoder emulator: queues same-direction step requests and plays each one
// out as a paced four-transition A/B detent, tracking the resulting detent position.
module ose_encoder_gen
    import ose_pkg::*;
#(
    parameter int unsigned phase_div = 4,
    parameter int unsigned depth     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_req,
    input  logic       step_up,
    output logic       step_ack,
    output logic       step_nack,
    output logic       step_done,
    output logic       busy,
    output logic       a,
    output logic       b,
    output logic [7:0] pos
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [2:0] DEPTH_C = 3'(depth);

    logic [0:0] state;
    logic [2:0] count;
    logic [2:0] count_next;
    logic       pend_dir;
    logic [1:0] phase_idx;
    logic [1:0] next_idx;
    logic       tick;
    logic       completing;
    logic       accept;
    logic       start_run;

    encoder_phase_timer #(
        .phase_div(phase_div)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .start(start_run),
        .run  (state == ST_RUN),
        .tick (tick)
    );

    // A slot freed by a completing detent this cycle may be reused by a coincident request.
    always_comb begin
        next_idx   = phase_idx + 2'd1;
        completing = (state == ST_RUN) && tick && (phase_idx == 2'd3);
        accept     = step_req &&
                     ((count == 3'd0) ||
                      ((step_up == pend_dir) && ((count < DEPTH_C) || completing)));
        start_run  = accept && (state == ST_IDLE);
        count_next = count;
        if (accept && !completing) begin
            count_next = count + 3'd1;
        end else if (!accept && completing) begin
            count_next = count - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= 3'd0;
            pend_dir  <= DIR_UP;
            phase_idx <= 2'd0;
            {a, b}    <= QS_11;
            pos       <= 8'd0;
            step_ack  <= 1'b0;
            step_nack <= 1'b0;
            step_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            step_ack  <= accept;
            step_nack <= step_req && !accept;
            step_done <= completing;
            count     <= count_next;
            busy      <= (count_next != 3'd0);
            state     <= (count_next != 3'd0) ? ST_RUN : ST_IDLE;
            // From idle the first transition goes out on the accepting edge itself.
            if (start_run) begin
                pend_dir  <= step_up;
                phase_idx <= 2'd1;
                {a, b}    <= quad_state(step_up, 2'd1);
            end else if ((state == ST_RUN) && tick) begin
                phase_idx <= next_idx;
                {a, b}    <= quad_state(pend_dir, next_idx);
                if (completing) begin
                    pos <= (pend_dir == DIR_UP) ? pos + 8'd1 : pos - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ose_encoder_gen.sv
// Scoreboard bench for ose_encoder_gen: a schedule-level model predicts responses,
// A/B transitions and detent completions; a monitor compares them as the DUT shows them.
module tb_ose_encoder_gen;

    localparam int P     = 4;
    localparam int DEPTH = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       step_req = 1'b0;
    logic       step_up  = 1'b0;
    logic       step_ack;
    logic       step_nack;
    logic       step_done;
    logic       busy;
    logic       a;
    logic       b;
    logic [7:0] pos;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    typedef struct {
        int acc;
        int done;
    } det_t;

    ev_t  resp_q[$];
    ev_t  wave_q[$];
    ev_t  done_q[$];
    det_t dets[$];

    logic       model_dir = 1'b1;
    int         last_done = 0;
    logic [7:0] sched_pos = 8'd0;
    logic [1:0] prev_ab   = 2'b11;
    bit         mon_en    = 1'b0;

    logic [1:0] up_seq[4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] dn_seq[4] = '{2'b10, 2'b00, 2'b01, 2'b11};

    ose_encoder_gen #(
        .phase_div(P),
        .depth    (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .step_req (step_req),
        .step_up  (step_up),
        .step_ack (step_ack),
        .step_nack(step_nack),
        .step_done(step_done),
        .busy     (busy),
        .a        (a),
        .b        (b),
        .pos      (pos)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: event not as required (cycle %0d)", name, cyc);
    endtask

    // Decide the fate of a request sampled at edge e and schedule its waveform.
    task automatic modelRequest(input int e, input logic up);
        int pending;
        bit completing;
        bit acc;
        int start;
        pending    = 0;
        completing = 1'b0;
        foreach (dets[i]) begin
            if (dets[i].done >= e) pending++;
            if (dets[i].done == e) completing = 1'b1;
        end
        acc = (pending == 0) || ((up == model_dir) && ((pending < DEPTH) || completing));
        resp_q.push_back('{e, acc ? 1 : 0});
        if (acc) begin
            if (pending == 0) begin
                model_dir = up;
                start     = e;
            end else begin
                start = last_done + P;
            end
            for (int i = 0; i < 4; i++) begin
                wave_q.push_back('{start + i * P, int'(up ? up_seq[i] : dn_seq[i])});
            end
            sched_pos = up ? sched_pos + 8'd1 : sched_pos - 8'd1;
            done_q.push_back('{start + 3 * P, int'(sched_pos)});
            dets.push_back('{e, start + 3 * P});
            last_done = start + 3 * P;
        end
    endtask

    // Called at a negedge; the request is sampled on the following posedge.
    task automatic applyStimulus(input logic req, input logic up);
        step_req = req;
        step_up  = up;
        if (req) modelRequest(cyc + 1, up);
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles);
        int i;
        i = 0;
        while ((i < max_cycles) && ((resp_q.size() != 0) || (wave_q.size() != 0) || (done_q.size() != 0))) begin
            applyStimulus(1'b0, 1'b0);
            i++;
        end
        if (i >= max_cycles) failNow("idle_timeout");
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_ab", int'({a, b}), 3);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_pos", int'(pos), 0);
        resp_q.delete();
        wave_q.delete();
        done_q.delete();
        dets.delete();
        sched_pos = 8'd0;
        prev_ab   = 2'b11;
        last_done = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t ev;
        bit  exp_busy;
        if (mon_en && !reset) begin
            if (step_ack || step_nack) begin
                if (resp_q.size() == 0) begin
                    failNow("resp_unexpected");
                end else begin
                    ev = resp_q.pop_front();
                    checkOutput("resp_cycle", cyc, ev.cyc);
                    checkOutput("resp_ack", int'(step_ack), ev.val);
                    checkOutput("resp_nack", int'(step_nack), 1 - ev.val);
                end
            end
            if ({a, b} != prev_ab) begin
                if (wave_q.size() == 0) begin
                    failNow("ab_unexpected");
                end else begin
                    ev = wave_q.pop_front();
                    checkOutput("ab_cycle", cyc, ev.cyc);
                    checkOutput("ab_value", int'({a, b}), ev.val);
                end
                prev_ab = {a, b};
            end
            if (step_done) begin
                if (done_q.size() == 0) begin
                    failNow("done_unexpected");
                end else begin
                    ev = done_q.pop_front();
                    checkOutput("done_cycle", cyc, ev.cyc);
                    checkOutput("done_pos", int'(pos), ev.val);
                end
            end
            exp_busy = 1'b0;
            foreach (dets[i]) begin
                if ((dets[i].acc <= cyc) && (dets[i].done > cyc)) exp_busy = 1'b1;
            end
            if (busy != exp_busy) checkOutput("busy", int'(busy), int'(exp_busy));
            else tests++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        logic dir;
        repeat (3) @(negedge clk);
        checkOutput("reset_ab", int'({a, b}), 3);
        checkOutput("reset_pos", int'(pos), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_pulses", int'({step_ack, step_nack, step_done}), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single up step sampled at edge 11.
        while (cyc < 10) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        waitIdle(40);
        checkOutput("single_up_pos", int'(pos), 1);

        // Single down step from pos 0 wraps to 255.
        doReset();
        applyStimulus(1'b1, 1'b0);
        waitIdle(40);
        checkOutput("single_dn_pos", int'(pos), 255);

        // Four consecutive up requests against depth 3.
        repeat (4) applyStimulus(1'b1, 1'b1);
        waitIdle(80);
        checkOutput("fill_pos", int'(pos), 2);
        checkOutput("fill_busy", int'(busy), 0);

        // Opposite direction refused while queued, accepted once idle.
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitIdle(40);
        applyStimulus(1'b1, 1'b0);
        waitIdle(40);
        checkOutput("conflict_pos", int'(pos), 2);

        // Request on the exact completion edge with a full queue.
        s = cyc + 1;
        repeat (3) applyStimulus(1'b1, 1'b1);
        while (cyc < s + 11) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("simul_ack", int'(step_ack), 1);
        checkOutput("simul_done", int'(step_done), 1);
        checkOutput("simul_busy", int'(busy), 1);
        waitIdle(120);
        checkOutput("simul_pos", int'(pos), 6);

        // Reset while (a,b)=00, then a fresh request.
        doReset();
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; (i < 20) && ({a, b} != 2'b00); i++) applyStimulus(1'b0, 1'b0);
        if ({a, b} != 2'b00) failNow("wait_ab00");
        doReset();
        applyStimulus(1'b1, 1'b1);
        waitIdle(40);
        checkOutput("post_reset_pos", int'(pos), 1);

        // Randomised traffic with a persistent-ish direction.
        dir = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 15) dir = ~dir;
            if ($urandom_range(0, 99) < 35) applyStimulus(1'b1, dir);
            else applyStimulus(1'b0, 1'b0);
        end
        waitIdle(200);

        checkOutput("final_resp_q", resp_q.size(), 0);
        checkOutput("final_wave_q", wave_q.size(), 0);
        checkOutput("final_done_q", done_q.size(), 0);
        checkOutput("final_ab", int'({a, b}), 3);
        checkOutput("final_pos", int'(pos), int'(sched_pos));
        checkOutput("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
